issue_scoreboard: RTL and testbench

Issue-control block between the instruction decoder and the execute stage. It tracks a per-register pending-write scoreboard and a count of in-flight writing instructions. It holds the decoder (stall) on RAW/WAW hazards or when the in-flight limit is reached. It also provides a drain sequence so the pipeline can be emptied before a control event.

---
 rtl/issue_scoreboard.sv | 126 ++++++++++++
 tb/tb_issue_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue control between decode and execute: per-register pending-write scoreboard,
// in-flight writer count, RAW/WAW stall generation and a drain handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal issue
// ST_DRAIN | issue blocked, waiting for the in-flight writers to retire
// ST_DONE  | pipeline empty; drained_o pulses on entry, held while drain_i is high
module issue_scoreboard #(
  parameter int LEN_REGNO    = 4,
  parameter int MAX_INFLIGHT = 3,
  parameter int LEN_CNT      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      stall_o,
  input  logic                      uses_rd_i,
  input  logic                      uses_rs_i,
  input  logic                      writes_rd_i,
  input  logic [LEN_REGNO-1:0]      rd_regno_i,
  input  logic [LEN_REGNO-1:0]      rs_regno_i,
  output logic                      issue_o,
  input  logic                      stall_i,
  input  logic                      wb_i,
  input  logic [LEN_REGNO-1:0]      wb_regno_i,
  input  logic                      flush_i,
  input  logic                      drain_i,
  output logic                      drained_o,
  output logic [(1<<LEN_REGNO)-1:0] busy_o,
  output logic [LEN_CNT-1:0]        inflight_o,
  output logic                      err_o
);

  localparam int NREG = 1 << LEN_REGNO;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [LEN_CNT-1:0] inflight_q, inflight_d;
  logic              drained_q;
  logic              err_q;

  logic hazard;
  logic hazard_eff;
  logic set_rd;
  logic wb_hit;
  logic wb_bad;

  always_comb begin
    hazard = (uses_rs_i & busy_q[rs_regno_i])
           | ((uses_rd_i | writes_rd_i) & busy_q[rd_regno_i])
           | (writes_rd_i & (inflight_q == LEN_CNT'(MAX_INFLIGHT)))
           | (state_q != ST_RUN);
  end

  // While reset is held the registered state may be stale, so it cannot stall.
  assign hazard_eff = rst & hazard;
  assign issue_o    = valid_i & ~hazard_eff & ~stall_i & ~flush_i;
  assign stall_o    = stall_i | (valid_i & hazard_eff);

  assign set_rd = issue_o & writes_rd_i;
  assign wb_hit = wb_i & busy_q[wb_regno_i];
  assign wb_bad = wb_i & ~busy_q[wb_regno_i];

  // Clear first, then set: a new writer to the retiring register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit) busy_d[wb_regno_i] = 1'b0;
    if (set_rd) busy_d[rd_regno_i] = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({set_rd, wb_hit})
      2'b10:   inflight_d = inflight_q + LEN_CNT'(1);
      2'b01:   inflight_d = inflight_q - LEN_CNT'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_i) state_d = ST_DRAIN;
      ST_DRAIN: if ((inflight_q == '0) || ((inflight_q == LEN_CNT'(1)) && wb_hit))
                  state_d = ST_DONE;
      ST_DONE:  if (!drain_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      busy_q     <= '0;
      inflight_q <= '0;
      drained_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_q | wb_bad;
      if (flush_i) begin
        state_q    <= ST_RUN;
        busy_q     <= '0;
        inflight_q <= '0;
        drained_q  <= 1'b0;
      end else begin
        state_q    <= state_d;
        busy_q     <= busy_d;
        inflight_q <= inflight_d;
        drained_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
      end
    end
  end

  assign busy_o     = busy_q;
  assign inflight_o = inflight_q;
  assign drained_o  = drained_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized
// traffic, all compared every cycle against a set/count behavioural model.
module tb_issue_scoreboard;

  localparam int LEN_REGNO = 4;
  localparam int MAXI      = 3;
  localparam int LEN_CNT   = 3;
  localparam int NREG      = 16;

  logic clk = 1'b0;
  logic rst, valid_i, stall_o, uses_rd_i, uses_rs_i, writes_rd_i;
  logic [LEN_REGNO-1:0] rd_regno_i, rs_regno_i, wb_regno_i;
  logic issue_o, stall_i, wb_i, flush_i, drain_i, drained_o, err_o;
  logic [NREG-1:0] busy_o;
  logic [LEN_CNT-1:0] inflight_o;

  int checks = 0;
  int errors = 0;

  // model: set of pending registers, writer count, drain phase
  bit m_busy[NREG];
  int m_cnt;
  int m_phase;    // 0 running, 1 draining, 2 drained
  bit m_drained;
  bit m_err;
  bit m_valid = 1'b0;

  issue_scoreboard #(.LEN_REGNO(LEN_REGNO), .MAX_INFLIGHT(MAXI), .LEN_CNT(LEN_CNT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_o),
    .uses_rd_i(uses_rd_i), .uses_rs_i(uses_rs_i), .writes_rd_i(writes_rd_i),
    .rd_regno_i(rd_regno_i), .rs_regno_i(rs_regno_i), .issue_o(issue_o),
    .stall_i(stall_i), .wb_i(wb_i), .wb_regno_i(wb_regno_i), .flush_i(flush_i),
    .drain_i(drain_i), .drained_o(drained_o), .busy_o(busy_o),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] m_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit m_hazard();
    if (!rst) return 1'b0;
    return (m_phase != 0) || (uses_rs_i && m_busy[rs_regno_i]) ||
           ((uses_rd_i || writes_rd_i) && m_busy[rd_regno_i]) ||
           (writes_rd_i && m_cnt == MAXI);
  endfunction

  function automatic bit m_issue();
    return valid_i && !m_hazard() && !stall_i && !flush_i;
  endfunction

  function automatic bit m_stall();
    return stall_i || (valid_i && m_hazard());
  endfunction

  task automatic model_edge();
    bit iss, retire;
    int next;
    if (!rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_cnt = 0; m_phase = 0; m_drained = 0; m_err = 0; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    retire = wb_i && m_busy[wb_regno_i];
    if (wb_i && !m_busy[wb_regno_i]) m_err = 1'b1;
    if (flush_i) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_cnt = 0; m_phase = 0; m_drained = 0;
      return;
    end
    iss = m_issue();
    next = m_phase;
    if (m_phase == 0 && drain_i) next = 1;
    else if (m_phase == 1 && (m_cnt == 0 || (m_cnt == 1 && retire))) next = 2;
    else if (m_phase == 2 && !drain_i) next = 0;
    m_drained = (next == 2) && (m_phase != 2);
    m_phase = next;
    if (retire) begin m_busy[wb_regno_i] = 1'b0; m_cnt--; end
    if (iss && writes_rd_i) begin m_busy[rd_regno_i] = 1'b1; m_cnt++; end
  endtask

  task automatic compare_all();
    if (!m_valid) return;
    chk("issue", 32'(issue_o), 32'(m_issue()));
    chk("stall", 32'(stall_o), 32'(m_stall()));
    chk("busy", 32'(busy_o), 32'(m_vec()));
    chk("inflight", 32'(inflight_o), 32'(m_cnt));
    chk("err", 32'(err_o), 32'(m_err));
    chk("drained", 32'(drained_o), 32'(m_drained));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic instr(input bit v, input bit urd, input bit urs, input bit wr,
                       input int rd, input int rs);
    valid_i = v; uses_rd_i = urd; uses_rs_i = urs; writes_rd_i = wr;
    rd_regno_i = LEN_REGNO'(rd); rs_regno_i = LEN_REGNO'(rs);
  endtask

  task automatic wb(input bit w, input int r);
    wb_i = w; wb_regno_i = LEN_REGNO'(r);
  endtask

  initial begin
    int start, pick;
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; drain_i = 1'b0;
    instr(1, 0, 0, 0, 0, 0); wb(0, 0);
    #1 chk("reset_issue", 32'(issue_o), 32'd1);
    tick(); tick();
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_inflight", 32'(inflight_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);

    // producer / consumer on r3
    rst = 1'b1; instr(1, 0, 0, 1, 3, 0);
    #1 chk("wr3_issue", 32'(issue_o), 32'd1);
    tick();
    chk("wr3_busy", 32'(busy_o), 32'h0008);
    chk("wr3_inflight", 32'(inflight_o), 32'd1);
    instr(1, 0, 1, 0, 0, 3);
    #1 chk("raw_stall", 32'(stall_o), 32'd1);
    chk("raw_issue", 32'(issue_o), 32'd0);
    wb(1, 3);
    #1 chk("raw_wb_stall", 32'(stall_o), 32'd1);
    tick();
    wb(0, 0);
    #1 chk("raw_after_wb_issue", 32'(issue_o), 32'd1);
    chk("raw_after_wb_busy", 32'(busy_o), 32'h0);
    tick();

    // fill to the in-flight limit
    for (int r = 1; r <= 3; r++) begin instr(1, 0, 0, 1, r, 0); tick(); end
    instr(1, 0, 0, 1, 4, 0);
    #1 chk("limit_stall", 32'(stall_o), 32'd1);
    instr(1, 0, 0, 1, 1, 0); wb(1, 1);
    #1 chk("waw_same_cycle_issue", 32'(issue_o), 32'd0);
    tick();
    wb(0, 0);
    #1 chk("waw_next_issue", 32'(issue_o), 32'd1);
    tick();
    chk("refill_busy", 32'(busy_o), 32'h000E);
    chk("refill_inflight", 32'(inflight_o), 32'd3);
    instr(1, 0, 0, 1, 4, 0);
    #1 chk("r4_still_stalled", 32'(stall_o), 32'd1);
    tick();

    // drain with two writers outstanding
    instr(0, 0, 0, 0, 0, 0); wb(1, 1); tick();
    wb(0, 0); drain_i = 1'b1; tick();
    instr(1, 0, 0, 1, 5, 0);
    #1 chk("drain_blocks", 32'(issue_o), 32'd0);
    wb(1, 2); tick();
    wb(1, 3); tick();
    wb(0, 0);
    chk("drained_pulse", 32'(drained_o), 32'd1);
    tick();
    chk("drained_once", 32'(drained_o), 32'd0);
    drain_i = 1'b0;
    #1 chk("done_blocks", 32'(issue_o), 32'd0);
    instr(1, 0, 0, 1, 4, 0); tick();
    #1 chk("resume_issue", 32'(issue_o), 32'd1);
    tick();
    instr(1, 0, 0, 1, 5, 0); tick();
    instr(1, 0, 0, 1, 6, 0); tick();
    chk("pre_flush_busy", 32'(busy_o), 32'h0070);

    // flush beats a ready read-only instruction
    instr(1, 0, 1, 0, 0, 0); flush_i = 1'b1;
    #1 chk("flush_issue", 32'(issue_o), 32'd0);
    tick();
    flush_i = 1'b0; instr(0, 0, 0, 0, 0, 0);
    chk("flush_busy", 32'(busy_o), 32'h0);
    chk("flush_inflight", 32'(inflight_o), 32'd0);

    // writeback to an idle register
    wb(1, 5); tick();
    wb(0, 0); tick(); tick();
    chk("err_sticky", 32'(err_o), 32'd1);
    chk("err_inflight", 32'(inflight_o), 32'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      instr($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) drain_i = ~drain_i;
      wb(0, $urandom_range(0, 15));
      if ($urandom_range(0, 99) < 45) begin
        start = $urandom_range(0, 15);
        for (int k = 0; k < NREG; k++) begin
          pick = (start + k) % NREG;
          if (m_busy[pick] && !wb_i) wb(1, pick);
        end
      end
      if ($urandom_range(0, 499) == 0) wb(1, $urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
